shot_resolver: RTL and testbench

Attack-phase counterpart to the ship-placement logic. While the attack phase is active, it takes a fire request at a target cell (row, col) from the player's active-low switch and looks the cell up in the opponent's placed-ship occupancy map. It records the shot in a shot history map, classifies the outcome, and counts hits. When every occupied cell has been hit, it flags `all_sunk` to the game controller. Its shot map feeds the VGA renderer.

---
 rtl/battleship_pkg.sv | 19 +
 rtl/cell_index.sv | 18 +
 rtl/shot_resolver.sv | 125 ++++++++++++
 tb/tb_shot_resolver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Types and constants shared by the battleship placement, attack and VGA blocks.
package battleship_pkg;

    localparam int BOARD_DIM_DEFAULT = 5;

    typedef enum logic [1:0] {
        MISS    = 2'd0,
        HIT     = 2'd1,
        REPEAT  = 2'd2,
        INVALID = 2'd3
    } shot_result_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HOLD  = 2'd2
    } shot_state_t;

endpackage

// File: rtl/cell_index.sv
// Maps a (row, col) board coordinate to its flat bit index plus an in-range flag.
module cell_index #(
    parameter int BOARD_DIM = 5,
    parameter int CELLS     = BOARD_DIM * BOARD_DIM,
    parameter int RW        = $clog2(BOARD_DIM),
    parameter int IW        = $clog2(CELLS)
) (
    input  logic [RW-1:0] row,
    input  logic [RW-1:0] col,
    output logic [IW-1:0] idx,
    output logic          in_range
);

    // Out-of-range coordinates wrap in idx; consumers must gate on in_range.
    assign idx      = IW'(row * BOARD_DIM + col);
    assign in_range = (32'(row) < BOARD_DIM) && (32'(col) < BOARD_DIM);

endmodule

// File: rtl/shot_resolver.sv
// Resolves fire requests against the opponent ship map, tracking shot history and hit count.
module shot_resolver
    import battleship_pkg::*;
#(
    parameter int BOARD_DIM = BOARD_DIM_DEFAULT,
    parameter int CELLS     = BOARD_DIM * BOARD_DIM,
    parameter int CW        = $clog2(CELLS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fire_n,
    input  logic                         attacking,
    input  logic                         new_game,
    input  logic [$clog2(BOARD_DIM)-1:0] row,
    input  logic [$clog2(BOARD_DIM)-1:0] col,
    input  logic [CELLS-1:0]             ship_map,
    input  logic [CW-1:0]                ship_cells,
    output logic [CELLS-1:0]             shot_map,
    output logic                         result_valid,
    output shot_result_t                 result,
    output logic [CW-1:0]                hits_count,
    output logic [CW-1:0]                shots_count,
    output logic                         all_sunk,
    output shot_state_t                  fsm_state
);

    localparam int RW = $clog2(BOARD_DIM);
    localparam int IW = $clog2(CELLS);

    shot_state_t  state, state_next;
    logic [RW-1:0] row_q, col_q;
    logic [IW-1:0] idx;
    logic          in_range;
    logic          latch, resolve;
    shot_result_t  verdict;

    cell_index #(
        .BOARD_DIM(BOARD_DIM),
        .CELLS    (CELLS),
        .RW       (RW),
        .IW       (IW)
    ) u_cell_index (
        .row     (row_q),
        .col     (col_q),
        .idx     (idx),
        .in_range(in_range)
    );

    assign all_sunk  = (hits_count == ship_cells) && (ship_cells != '0);
    assign fsm_state = state;

    // Priority INVALID > REPEAT > HIT > MISS; idx is only trusted once in range.
    always_comb begin
        verdict = MISS;
        if (!in_range)          verdict = INVALID;
        else if (shot_map[idx]) verdict = REPEAT;
        else if (ship_map[idx]) verdict = HIT;
    end

    always_comb begin
        state_next = state;
        latch      = 1'b0;
        resolve    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fire_n && attacking && !all_sunk) begin
                    latch      = 1'b1;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                resolve    = 1'b1;
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (fire_n) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (new_game) begin
            state_next = S_IDLE;
            latch      = 1'b0;
            resolve    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            shot_map     <= '0;
            hits_count   <= '0;
            shots_count  <= '0;
            result       <= MISS;
            result_valid <= 1'b0;
        end else begin
            result_valid <= resolve;
            if (new_game) begin
                shot_map    <= '0;
                hits_count  <= '0;
                shots_count <= '0;
                result      <= MISS;
            end else begin
                if (latch) begin
                    row_q <= row;
                    col_q <= col;
                end
                if (resolve) begin
                    result <= verdict;
                    if (verdict == HIT || verdict == MISS) begin
                        shot_map[idx] <= 1'b1;
                        shots_count   <= shots_count + CW'(1);
                    end
                    if (verdict == HIT) hits_count <= hits_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver on a 5x5 board with ships on cells 0, 1 and 2.
module tb_shot_resolver;
    import battleship_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fire_n = 1'b1;
    logic         attacking = 1'b1;
    logic         new_game = 1'b0;
    logic [2:0]   row = '0;
    logic [2:0]   col = '0;
    logic [24:0]  ship_map = 25'h7;
    logic [4:0]   ship_cells = 5'd3;
    logic [24:0]  shot_map;
    logic         result_valid;
    shot_result_t result;
    logic [4:0]   hits_count;
    logic [4:0]   shots_count;
    logic         all_sunk;
    shot_state_t  fsm_state;

    int total = 0;
    int bad   = 0;

    shot_resolver #(.BOARD_DIM(5)) dut (
        .clk(clk), .rst(rst), .fire_n(fire_n), .attacking(attacking),
        .new_game(new_game), .row(row), .col(col), .ship_map(ship_map),
        .ship_cells(ship_cells), .shot_map(shot_map), .result_valid(result_valid),
        .result(result), .hits_count(hits_count), .shots_count(shots_count),
        .all_sunk(all_sunk), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1; fire_n = 1'b1; new_game = 1'b0; attacking = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Press for 'hold' cycles, release, and count result_valid cycles seen meanwhile.
    task automatic shoot(input logic [2:0] r, input logic [2:0] c, input int hold,
                         output int pulses, output shot_result_t last);
        pulses = 0;
        last   = MISS;
        row = r; col = c; fire_n = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (result_valid) begin pulses++; last = result; end
        end
        fire_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (result_valid) begin pulses++; last = result; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (shot_map !== 25'h0) begin bad++; $display("FAIL reset_map got=%h exp=0", shot_map); end
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b exp=0", result_valid); end
        total++; if (result !== MISS) begin bad++; $display("FAIL reset_result got=%0d exp=0", result); end
        total++; if ({hits_count, shots_count} !== 10'h0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hits_count, shots_count); end
        total++; if (all_sunk !== 1'b0) begin bad++; $display("FAIL reset_sunk got=%b exp=0", all_sunk); end
        total++; if (fsm_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_first_hit();
        do_reset();
        row = 3'd0; col = 3'd0; fire_n = 1'b0;
        @(negedge clk);
        total++; if (fsm_state !== S_CHECK || result_valid !== 1'b0) begin bad++; $display("FAIL hit_check_cycle state=%0d rv=%b exp=1/0", fsm_state, result_valid); end
        @(negedge clk);
        total++; if (result_valid !== 1'b1) begin bad++; $display("FAIL hit_pulse got=%b exp=1", result_valid); end
        total++; if (result !== HIT) begin bad++; $display("FAIL hit_result got=%0d exp=1", result); end
        total++; if (hits_count !== 5'd1 || shots_count !== 5'd1) begin bad++; $display("FAIL hit_counts got=%0d/%0d exp=1/1", hits_count, shots_count); end
        total++; if (shot_map !== 25'h1) begin bad++; $display("FAIL hit_map got=%h exp=1", shot_map); end
        fire_n = 1'b1;
        @(negedge clk);
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL hit_pulse_width got=%b exp=0", result_valid); end
        total++; if (result !== HIT) begin bad++; $display("FAIL hit_result_held got=%0d exp=1", result); end
        total++; if (fsm_state !== S_IDLE) begin bad++; $display("FAIL hit_back_idle got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_miss_repeat();
        int p; shot_result_t r;
        do_reset();
        shoot(3'd4, 3'd4, 3, p, r);
        total++; if (p !== 1 || r !== MISS) begin bad++; $display("FAIL miss pulses=%0d res=%0d exp=1/0", p, r); end
        total++; if (shot_map !== 25'h100_0000) begin bad++; $display("FAIL miss_map got=%h exp=1000000", shot_map); end
        shoot(3'd4, 3'd4, 3, p, r);
        total++; if (p !== 1 || r !== REPEAT) begin bad++; $display("FAIL repeat pulses=%0d res=%0d exp=1/2", p, r); end
        total++; if (hits_count !== 5'd0 || shots_count !== 5'd1) begin bad++; $display("FAIL repeat_counts got=%0d/%0d exp=0/1", hits_count, shots_count); end
    endtask

    task automatic test_hold_once();
        int p; shot_result_t r;
        do_reset();
        shoot(3'd2, 3'd3, 20, p, r);
        total++; if (p !== 1) begin bad++; $display("FAIL hold_single_pulse got=%0d exp=1", p); end
        shoot(3'd3, 3'd2, 20, p, r);
        total++; if (p !== 1 || r !== MISS) begin bad++; $display("FAIL hold_second pulses=%0d res=%0d exp=1/0", p, r); end
        total++; if (shots_count !== 5'd2) begin bad++; $display("FAIL hold_shots got=%0d exp=2", shots_count); end
    endtask

    task automatic test_all_sunk();
        int p; shot_result_t r;
        do_reset();
        shoot(3'd0, 3'd0, 2, p, r);
        shoot(3'd0, 3'd1, 2, p, r);
        total++; if (all_sunk !== 1'b0) begin bad++; $display("FAIL sunk_early got=%b exp=0", all_sunk); end
        row = 3'd0; col = 3'd2; fire_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (result_valid !== 1'b1 || all_sunk !== 1'b1) begin bad++; $display("FAIL sunk_with_pulse rv=%b sunk=%b exp=1/1", result_valid, all_sunk); end
        total++; if (hits_count !== 5'd3) begin bad++; $display("FAIL sunk_hits got=%0d exp=3", hits_count); end
        fire_n = 1'b1;
        repeat (2) @(negedge clk);
        shoot(3'd3, 3'd3, 4, p, r);
        total++; if (p !== 0) begin bad++; $display("FAIL sunk_ignored pulses=%0d exp=0", p); end
        total++; if (shot_map !== 25'h7 || shots_count !== 5'd3) begin bad++; $display("FAIL sunk_map got=%h/%0d exp=7/3", shot_map, shots_count); end
    endtask

    task automatic test_invalid_gate();
        int p; shot_result_t r;
        do_reset();
        shoot(3'd5, 3'd0, 3, p, r);
        total++; if (p !== 1 || r !== INVALID) begin bad++; $display("FAIL invalid pulses=%0d res=%0d exp=1/3", p, r); end
        total++; if (shot_map !== 25'h0 || shots_count !== 5'd0 || hits_count !== 5'd0) begin bad++; $display("FAIL invalid_nochange map=%h shots=%0d hits=%0d exp=0/0/0", shot_map, shots_count, hits_count); end
        shoot(3'd1, 3'd7, 3, p, r);
        total++; if (r !== INVALID || shots_count !== 5'd0) begin bad++; $display("FAIL invalid_col res=%0d shots=%0d exp=3/0", r, shots_count); end
        attacking = 1'b0;
        shoot(3'd0, 3'd1, 4, p, r);
        total++; if (p !== 0 || shot_map !== 25'h0) begin bad++; $display("FAIL not_attacking pulses=%0d map=%h exp=0/0", p, shot_map); end
        attacking = 1'b1;
    endtask

    task automatic test_new_game_reset();
        int p; shot_result_t r;
        do_reset();
        shoot(3'd4, 3'd4, 2, p, r);
        row = 3'd0; col = 3'd1; fire_n = 1'b0;
        @(negedge clk);
        new_game = 1'b1; fire_n = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        total++; if (result_valid !== 1'b0 || fsm_state !== S_IDLE) begin bad++; $display("FAIL ng_check rv=%b state=%0d exp=0/0", result_valid, fsm_state); end
        total++; if (shot_map !== 25'h0 || hits_count !== 5'd0 || shots_count !== 5'd0) begin bad++; $display("FAIL ng_clear map=%h hits=%0d shots=%0d exp=0/0/0", shot_map, hits_count, shots_count); end
        @(negedge clk);
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL ng_no_late_pulse got=%b exp=0", result_valid); end
        row = 3'd0; col = 3'd0; fire_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (fsm_state !== S_HOLD || hits_count !== 5'd1) begin bad++; $display("FAIL rst_setup state=%0d hits=%0d exp=2/1", fsm_state, hits_count); end
        rst = 1'b1;
        #1;
        total++; if (fsm_state !== S_IDLE || shot_map !== 25'h0 || result !== MISS) begin bad++; $display("FAIL async_rst state=%0d map=%h res=%0d exp=0/0/0", fsm_state, shot_map, result); end
        total++; if (hits_count !== 5'd0 || shots_count !== 5'd0 || result_valid !== 1'b0 || all_sunk !== 1'b0) begin bad++; $display("FAIL async_rst_counts hits=%0d shots=%0d rv=%b sunk=%b exp=0", hits_count, shots_count, result_valid, all_sunk); end
        fire_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_hit();
        test_miss_repeat();
        test_hold_once();
        test_all_sunk();
        test_invalid_gate();
        test_new_game_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
